// File: rtl/gf2m_pkg.sv
// Shared constants and GF(2^16) reduction helpers for the reduction pipeline.
// Pure package: no state, no latency.
// Backpressure: not applicable.
package gf2m_pkg;

  localparam int M = 16;
  localparam int PW = 2*M - 1;
  localparam int FOLD = 5;
  localparam logic [M-1:0] POLY_DEF = 16'h100B;

  typedef logic [PW-1:0] rem_t;
  typedef logic [M-1:0]  elem_t;

  // Number of fold stages needed to clear bits [PW-1:M], FOLD bits at a time.
  function automatic int stages_f(input int m, input int fold);
    return (m - 1 + fold - 1) / fold;
  endfunction

  localparam int STAGES = stages_f(M, FOLD);

  // Clear bits hi..lo of r (MSB first) by xoring in shifted copies of x^M + poly.
  // Bounds are elaboration constants at every RTL call site, so this unrolls to an XOR tree.
  function automatic rem_t gf_fold(input rem_t r, input int hi, input int lo, input elem_t poly);
    rem_t red;
    rem_t p;
    p   = rem_t'({1'b1, poly});
    red = r;
    for (int k = PW - 1; k >= M; k--) begin
      if (k <= hi && k >= lo && red[k]) begin
        red = red ^ (p << (k - M));
      end
    end
    return red;
  endfunction

  // Full single-shot reduction of a product modulo x^M + poly.
  function automatic elem_t gf_mod(input rem_t r, input elem_t poly);
    return elem_t'(gf_fold(r, PW - 1, M, poly));
  endfunction

endpackage

// File: rtl/gf2m_fold_stage.sv
// One pipeline slice: registers a remainder with FOLD high-order bits cleared, plus tag and valid.
// Latency: 1 cycle per slice.
// Backpressure: accepts whenever empty or downstream advances; holds otherwise.
module gf2m_fold_stage
  import gf2m_pkg::*;
#(
  parameter int          S     = 0,
  parameter logic [M-1:0] POLY = POLY_DEF,
  parameter int          TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             src_vld_i,
  input  rem_t             src_rem_i,
  input  logic [TAG_W-1:0] src_tag_i,
  input  logic             dn_adv_i,
  output logic             adv_o,
  output logic             vld_o,
  output rem_t             rem_o,
  output logic [TAG_W-1:0] tag_o
);

  // Bit window this slice clears; the last slice stops at bit M.
  localparam int HI     = PW - 1 - S*FOLD;
  localparam int LO_RAW = PW - (S + 1)*FOLD;
  localparam int LO     = (LO_RAW > M) ? LO_RAW : M;

  logic             vld_q, vld_d;
  rem_t             rem_q, rem_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  rem_t             fold_w;

  assign fold_w = gf_fold(src_rem_i, HI, LO, POLY);

  // Advance/load decision; data only captured with a valid source so idle X cannot leak in.
  always_comb begin
    adv_o = ~vld_q | dn_adv_i;
    vld_d = vld_q;
    rem_d = rem_q;
    tag_d = tag_q;
    if (clr_i) begin
      vld_d = 1'b0;
    end else if (adv_o) begin
      vld_d = src_vld_i;
      if (src_vld_i) begin
        rem_d = fold_w;
        tag_d = src_tag_i;
      end
    end
  end

  // Slice state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      rem_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      rem_q <= rem_d;
      tag_q <= tag_d;
    end
  end

  assign vld_o = vld_q;
  assign rem_o = rem_q;
  assign tag_o = tag_q;

endmodule

// File: rtl/gf2m_reduce_pipe.sv
// Reduces a 31-bit carry-less product modulo x^16+x^12+x^3+x+1 through STAGES fold slices.
// Latency: STAGES (3) cycles, throughput 1/cycle.
// Backpressure: in_ready is combinational from out_ready; empty slices always accept.
module gf2m_reduce_pipe
  import gf2m_pkg::*;
#(
  parameter logic [M-1:0] POLY  = POLY_DEF,
  parameter int           TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  rem_t             in_prod,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output elem_t            out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic [15:0]      out_cnt
);

  logic [STAGES:0]   adv;
  logic [STAGES-1:0] vld;
  rem_t              rem [STAGES];
  logic [TAG_W-1:0]  tag [STAGES];
  logic [15:0]       cnt_q, cnt_d;

  assign adv[STAGES] = out_ready;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic             src_vld;
    rem_t             src_rem;
    logic [TAG_W-1:0] src_tag;

    if (s == 0) begin : g_first
      assign src_vld = in_valid;
      assign src_rem = in_prod;
      assign src_tag = in_tag;
    end else begin : g_rest
      assign src_vld = vld[s-1];
      assign src_rem = rem[s-1];
      assign src_tag = tag[s-1];
    end

    gf2m_fold_stage #(
      .S     (s),
      .POLY  (POLY),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (clr),
      .src_vld_i (src_vld),
      .src_rem_i (src_rem),
      .src_tag_i (src_tag),
      .dn_adv_i  (adv[s+1]),
      .adv_o     (adv[s]),
      .vld_o     (vld[s]),
      .rem_o     (rem[s]),
      .tag_o     (tag[s])
    );
  end

  assign in_ready  = adv[0];
  assign out_valid = vld[STAGES-1];
  assign out_res   = rem[STAGES-1][M-1:0];
  assign out_tag   = tag[STAGES-1];
  assign busy      = |vld;

  // Last slice must have cleared every bit at or above x^M.
  hi_clear_a: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> (rem[STAGES-1][PW-1:M] == '0));

  // Accepted-output counter, saturating; survives clr.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_cnt = cnt_q;

endmodule
